// File: rtl/seq_mult_sa.sv
// seq_mult_sa: sequential shift-add multiplier with valid/ready handshakes.
//
// It computes one partial product per clock, LSB of the multiplier first.
// Each transaction can be signed (two's complement) or unsigned.
// The full 2*WIDTH-bit product is ready WIDTH cycles after the operands are
// accepted, independent of the data.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operands/mode valid
//   in_ready     block can accept operands (high only in IDLE)
//   a, b         multiplicand / multiplier, WIDTH bits
//   signed_mode  1 = two's-complement operands, 0 = unsigned (sampled at accept)
//   out_valid    product valid
//   out_ready    consumer accepts product
//   p            2*WIDTH-bit product, held until the next result loads
//   busy         high while a transaction is in CALC or DONE
module seq_mult_sa #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  mag_a;
    logic [WIDTH-1:0]  mag_b;
    logic              neg;
    logic [PW-1:0]     acc;
    logic [CW-1:0]     cnt;

    logic [WIDTH-1:0]  abs_a;
    logic [WIDTH-1:0]  abs_b;
    logic [PW-1:0]     addend;
    logic [PW-1:0]     sum;

    // Operand magnitudes and the running sum for the current multiplier bit.
    // The most-negative operand negates to 2^(WIDTH-1). That value still
    // fits in an unsigned WIDTH-bit magnitude, so the plain negation is safe.
    // The partial product is widened before shifting so that no high bits
    // are lost.
    always_comb begin
        abs_a = a;
        abs_b = b;
        if (signed_mode && a[WIDTH-1]) begin
            abs_a = -a;
        end
        if (signed_mode && b[WIDTH-1]) begin
            abs_b = -b;
        end
        addend = '0;
        if (mag_b[0]) begin
            addend = {{WIDTH{1'b0}}, mag_a} << cnt;
        end
        sum = acc + addend;
    end

    // Control FSM and datapath registers.
    // The edge that handles the last multiplier bit writes the sign-corrected
    // final sum straight into p, which removes the need for an extra fix-up
    // cycle. p is only written on that edge, so it keeps the last result
    // after the output handshake completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mag_a     <= '0;
            mag_b     <= '0;
            neg       <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            p         <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag_a <= abs_a;
                        mag_b <= abs_b;
                        neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc   <= '0;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc   <= sum;
                    mag_b <= mag_b >> 1;
                    cnt   <= cnt + CNT_ONE;
                    if (cnt == LAST_BIT) begin
                        p         <= neg ? -sum : sum;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_seq_mult_sa.sv
// tb_seq_mult_sa: directed self-checking bench for seq_mult_sa.
// It drives a WIDTH=8 instance and a WIDTH=16 instance from one clock and
// one reset. Expected values are hand-computed constants, except in the
// back-to-back run, where they come from a plain integer multiply.
module tb_seq_mult_sa;

    logic        clk;
    logic        rst_n;

    logic        in_valid_8;
    logic        in_ready_8;
    logic [7:0]  a_8;
    logic [7:0]  b_8;
    logic        sm_8;
    logic        out_valid_8;
    logic        out_ready_8;
    logic [15:0] p_8;
    logic        busy_8;

    logic        in_valid_16;
    logic        in_ready_16;
    logic [15:0] a_16;
    logic [15:0] b_16;
    logic        sm_16;
    logic        out_valid_16;
    logic        out_ready_16;
    logic [31:0] p_16;
    logic        busy_16;

    int passed;
    int total;
    int cyc;

    seq_mult_sa #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid_8),
        .in_ready    (in_ready_8),
        .a           (a_8),
        .b           (b_8),
        .signed_mode (sm_8),
        .out_valid   (out_valid_8),
        .out_ready   (out_ready_8),
        .p           (p_8),
        .busy        (busy_8)
    );

    seq_mult_sa #(.WIDTH(16)) dut16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid_16),
        .in_ready    (in_ready_16),
        .a           (a_16),
        .b           (b_16),
        .signed_mode (sm_16),
        .out_valid   (out_valid_16),
        .out_ready   (out_ready_16),
        .p           (p_16),
        .busy        (busy_16)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and then settle 1 unit past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Single comparison point: counts every check and every pass.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Runs one full WIDTH=8 transaction with out_ready high. It checks the
    // accept handshake, the exact 8-cycle latency, the product value and the
    // return to IDLE.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic sm,
                                 input logic [15:0] exp, input string tag);
        a_8 = av;
        b_8 = bv;
        sm_8 = sm;
        out_ready_8 = 1'b1;
        in_valid_8 = 1'b1;
        checkOutput({tag, "_ready_pre"}, 64'(in_ready_8), 64'd1);
        tick();
        in_valid_8 = 1'b0;
        checkOutput({tag, "_ready_drop"}, 64'(in_ready_8), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy_8), 64'd1);
        repeat (7) tick();
        checkOutput({tag, "_valid_early"}, 64'(out_valid_8), 64'd0);
        tick();
        checkOutput({tag, "_valid"}, 64'(out_valid_8), 64'd1);
        checkOutput({tag, "_p"}, 64'(p_8), 64'(exp));
        tick();
        checkOutput({tag, "_valid_clr"}, 64'(out_valid_8), 64'd0);
        checkOutput({tag, "_ready_back"}, 64'(in_ready_8), 64'd1);
        checkOutput({tag, "_p_hold"}, 64'(p_8), 64'(exp));
    endtask

    // The same transaction on the WIDTH=16 instance, which has 16-cycle latency.
    task automatic applyStimulusWide(input logic [15:0] av, input logic [15:0] bv, input logic sm,
                                     input logic [31:0] exp, input string tag);
        a_16 = av;
        b_16 = bv;
        sm_16 = sm;
        out_ready_16 = 1'b1;
        in_valid_16 = 1'b1;
        tick();
        in_valid_16 = 1'b0;
        repeat (15) tick();
        checkOutput({tag, "_valid_early"}, 64'(out_valid_16), 64'd0);
        tick();
        checkOutput({tag, "_valid"}, 64'(out_valid_16), 64'd1);
        checkOutput({tag, "_p"}, 64'(p_16), 64'(exp));
        tick();
        checkOutput({tag, "_ready_back"}, 64'(in_ready_16), 64'd1);
    endtask

    initial begin
        logic [7:0]  ra [4];
        logic [7:0]  rb [4];
        logic [15:0] rexp [4];
        int          seen [4];
        int          n;

        passed = 0;
        total = 0;
        cyc = 0;
        rst_n = 1'b0;
        in_valid_8 = 1'b0;
        a_8 = '0;
        b_8 = '0;
        sm_8 = 1'b0;
        out_ready_8 = 1'b0;
        in_valid_16 = 1'b0;
        a_16 = '0;
        b_16 = '0;
        sm_16 = 1'b0;
        out_ready_16 = 1'b0;

        // Reset state.
        repeat (2) tick();
        checkOutput("rst_p8", 64'(p_8), 64'd0);
        checkOutput("rst_valid8", 64'(out_valid_8), 64'd0);
        checkOutput("rst_ready8", 64'(in_ready_8), 64'd1);
        checkOutput("rst_busy8", 64'(busy_8), 64'd0);
        checkOutput("rst_p16", 64'(p_16), 64'd0);
        checkOutput("rst_ready16", 64'(in_ready_16), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Unsigned, signed and mode-dependent products.
        applyStimulus(8'd255, 8'd255, 1'b0, 16'hFE01, "u255x255");
        applyStimulus(8'h80, 8'h80, 1'b1, 16'h4000, "s_m128xm128");
        applyStimulus(8'hFD, 8'h05, 1'b1, 16'hFFF1, "s_m3x5");
        applyStimulus(8'h7F, 8'h80, 1'b1, 16'hC080, "s_127xm128");
        applyStimulus(8'hFD, 8'h05, 1'b0, 16'h04F1, "u253x5");
        applyStimulus(8'h00, 8'hAB, 1'b1, 16'h0000, "s_zero");

        // Backpressure: the result must hold while out_ready is low, and new
        // operands offered during that window must be ignored.
        a_8 = 8'd12;
        b_8 = 8'd13;
        sm_8 = 1'b0;
        out_ready_8 = 1'b0;
        in_valid_8 = 1'b1;
        tick();
        in_valid_8 = 1'b0;
        repeat (8) tick();
        checkOutput("bp_valid", 64'(out_valid_8), 64'd1);
        a_8 = 8'd99;
        b_8 = 8'd77;
        for (int i = 0; i < 5; i++) begin
            in_valid_8 = (i % 2 == 0);
            tick();
            checkOutput("bp_valid_hold", 64'(out_valid_8), 64'd1);
            checkOutput("bp_p_hold", 64'(p_8), 64'd156);
            checkOutput("bp_ready_low", 64'(in_ready_8), 64'd0);
        end
        in_valid_8 = 1'b0;
        out_ready_8 = 1'b1;
        tick();
        checkOutput("bp_drain_valid", 64'(out_valid_8), 64'd0);
        checkOutput("bp_drain_ready", 64'(in_ready_8), 64'd1);
        tick();
        checkOutput("bp_single_hs", 64'(out_valid_8), 64'd0);
        checkOutput("bp_idle", 64'(busy_8), 64'd0);
        checkOutput("bp_p_after", 64'(p_8), 64'd156);

        // Reset asserted mid-CALC drops the transaction immediately.
        a_8 = 8'd50;
        b_8 = 8'd60;
        in_valid_8 = 1'b1;
        tick();
        in_valid_8 = 1'b0;
        repeat (3) tick();
        checkOutput("mid_busy", 64'(busy_8), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 64'(out_valid_8), 64'd0);
        checkOutput("mid_rst_p", 64'(p_8), 64'd0);
        checkOutput("mid_rst_ready", 64'(in_ready_8), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_valid", 64'(out_valid_8), 64'd0);
        applyStimulus(8'd2, 8'd3, 1'b0, 16'd6, "post_rst_2x3");

        // WIDTH=16 instance.
        applyStimulusWide(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "w16_u_max");
        applyStimulusWide(16'h8000, 16'hFFFF, 1'b1, 32'h00008000, "w16_s_min_x_m1");

        // Back-to-back with in_valid held high: results must be WIDTH+2 apart.
        for (int i = 0; i < 4; i++) begin
            ra[i] = 8'($urandom_range(255, 0));
            rb[i] = 8'($urandom_range(255, 0));
            rexp[i] = {8'd0, ra[i]} * {8'd0, rb[i]};
        end
        sm_8 = 1'b0;
        out_ready_8 = 1'b1;
        a_8 = ra[0];
        b_8 = rb[0];
        in_valid_8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!out_valid_8 && n < 40) begin
                tick();
                n++;
            end
            checkOutput("b2b_timeout", 64'(n < 40), 64'd1);
            checkOutput("b2b_p", 64'(p_8), 64'(rexp[i]));
            seen[i] = cyc;
            if (i > 0) begin
                checkOutput("b2b_spacing", 64'(seen[i] - seen[i-1]), 64'd10);
            end
            if (i < 3) begin
                a_8 = ra[i+1];
                b_8 = rb[i+1];
            end else begin
                in_valid_8 = 1'b0;
            end
            tick();
        end
        checkOutput("b2b_end_idle", 64'(in_ready_8), 64'd1);

        $display("[TB] directed sequence complete");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
